// File: rtl/iagu_conv_stream.sv
// Input-address generator for convolution layers.
// Latches a layer descriptor on start and walks the loop nest
// out_group > in_piece > kernel_row > kernel_col > out_row > out_col.
// Each step is one beat on a valid/ready stream: an IO-buffer address or a pad beat.
// A weight-load-end pulse from WAGU releases each (out_group, in_piece) pass.
module iagu_conv_stream #(
    parameter int ADDR_W   = 12,
    parameter int DIM_W    = 8,
    parameter int KER_W    = 4,
    parameter int STRIDE_W = 2,
    parameter int PAD_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              wgt_load_end,
    input  logic [ADDR_W-1:0] addr_start,
    input  logic [DIM_W-1:0]  in_x_len,
    input  logic [DIM_W-1:0]  in_y_len,
    input  logic [DIM_W-1:0]  in_piece,
    input  logic [DIM_W-1:0]  out_x_len,
    input  logic [DIM_W-1:0]  out_y_len,
    input  logic [DIM_W-1:0]  out_group,
    input  logic [KER_W-1:0]  kernel,
    input  logic [STRIDE_W-1:0] stride,
    input  logic [PAD_W-1:0]  pad,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_pad,
    output logic              o_rd_en,
    output logic              o_feature_end,
    output logic              o_done,
    output logic              o_busy
);

    // Signed width wide enough for oy*s + kr - p without overflow.
    localparam int SW = DIM_W + 3;

    typedef enum logic [1:0] {IDLE, WAIT_WGT, RUN, FIN} state_t;

    state_t state_reg, state_next;

    // Latched descriptor
    logic [ADDR_W-1:0]   base_reg;
    logic [DIM_W-1:0]    in_x_reg, in_y_reg, piece_reg, ox_len_reg, oy_len_reg, group_reg;
    logic [KER_W-1:0]    k_reg;
    logic [STRIDE_W-1:0] s_reg;
    logic [PAD_W-1:0]    p_reg;

    // Loop counters; kr..ox describe the beat currently presented
    logic [DIM_W-1:0] og_reg, og_next, ip_reg, ip_next, oy_reg, oy_next, ox_reg, ox_next;
    logic [KER_W-1:0] kr_reg, kr_next, kc_reg, kc_next;

    logic              valid_reg, pad_reg, done_reg, done_next;
    logic [ADDR_W-1:0] addr_reg;

    logic accept, last_ox, last_oy, last_kc, last_kr, pass_last, final_pass, cfg_zero;
    logic load_beat, clear_beat;

    logic signed [SW-1:0] iy, ix;
    logic                 pad_calc;
    logic [ADDR_W-1:0]    addr_calc;

    assign accept     = valid_reg & i_ready & (state_reg == RUN);
    assign last_ox    = (ox_reg == ox_len_reg - DIM_W'(1));
    assign last_oy    = (oy_reg == oy_len_reg - DIM_W'(1));
    assign last_kc    = (kc_reg == k_reg - KER_W'(1));
    assign last_kr    = (kr_reg == k_reg - KER_W'(1));
    assign pass_last  = last_ox & last_oy & last_kc & last_kr;
    assign final_pass = (og_reg == group_reg - DIM_W'(1)) & (ip_reg == piece_reg - DIM_W'(1));
    assign cfg_zero   = (in_piece == '0) | (out_x_len == '0) | (out_y_len == '0) |
                        (out_group == '0) | (kernel == '0);

    // Address of the beat described by the next counter values
    always_comb begin
        iy = $signed(SW'(oy_next)) * $signed(SW'(s_reg)) + $signed(SW'(kr_next)) - $signed(SW'(p_reg));
        ix = $signed(SW'(ox_next)) * $signed(SW'(s_reg)) + $signed(SW'(kc_next)) - $signed(SW'(p_reg));
        pad_calc = (iy < 0) || (iy >= $signed(SW'(in_y_reg))) ||
                   (ix < 0) || (ix >= $signed(SW'(in_x_reg)));
        addr_calc = base_reg
                  + ADDR_W'(ip_next) * ADDR_W'(in_x_reg) * ADDR_W'(in_y_reg)
                  + ADDR_W'(iy) * ADDR_W'(in_x_reg)
                  + ADDR_W'(ix);
    end

    // Next-state, counter advance and beat load/clear decisions
    always_comb begin
        state_next = state_reg;
        og_next    = og_reg;
        ip_next    = ip_reg;
        kr_next    = kr_reg;
        kc_next    = kc_reg;
        oy_next    = oy_reg;
        ox_next    = ox_reg;
        done_next  = 1'b0;
        load_beat  = 1'b0;
        clear_beat = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    og_next    = '0;
                    ip_next    = '0;
                    state_next = cfg_zero ? FIN : WAIT_WGT;
                end
            end
            WAIT_WGT: begin
                if (wgt_load_end) begin
                    kr_next    = '0;
                    kc_next    = '0;
                    oy_next    = '0;
                    ox_next    = '0;
                    load_beat  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    if (pass_last) begin
                        clear_beat = 1'b1;
                        kr_next    = '0;
                        kc_next    = '0;
                        oy_next    = '0;
                        ox_next    = '0;
                        if (final_pass) begin
                            state_next = FIN;
                        end else begin
                            state_next = WAIT_WGT;
                            if (ip_reg == piece_reg - DIM_W'(1)) begin
                                ip_next = '0;
                                og_next = og_reg + DIM_W'(1);
                            end else begin
                                ip_next = ip_reg + DIM_W'(1);
                            end
                        end
                    end else begin
                        load_beat = 1'b1;
                        if (!last_ox) begin
                            ox_next = ox_reg + DIM_W'(1);
                        end else begin
                            ox_next = '0;
                            if (!last_oy) begin
                                oy_next = oy_reg + DIM_W'(1);
                            end else begin
                                oy_next = '0;
                                if (!last_kc) begin
                                    kc_next = kc_reg + KER_W'(1);
                                end else begin
                                    kc_next = '0;
                                    kr_next = kr_reg + KER_W'(1);
                                end
                            end
                        end
                    end
                end
            end
            FIN: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counters, descriptor latch and registered beat outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            base_reg   <= '0;
            in_x_reg   <= '0;
            in_y_reg   <= '0;
            piece_reg  <= '0;
            ox_len_reg <= '0;
            oy_len_reg <= '0;
            group_reg  <= '0;
            k_reg      <= '0;
            s_reg      <= '0;
            p_reg      <= '0;
            og_reg     <= '0;
            ip_reg     <= '0;
            kr_reg     <= '0;
            kc_reg     <= '0;
            oy_reg     <= '0;
            ox_reg     <= '0;
            valid_reg  <= 1'b0;
            pad_reg    <= 1'b0;
            addr_reg   <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            og_reg    <= og_next;
            ip_reg    <= ip_next;
            kr_reg    <= kr_next;
            kc_reg    <= kc_next;
            oy_reg    <= oy_next;
            ox_reg    <= ox_next;
            done_reg  <= done_next;
            if (state_reg == IDLE && start) begin
                base_reg   <= addr_start;
                in_x_reg   <= in_x_len;
                in_y_reg   <= in_y_len;
                piece_reg  <= in_piece;
                ox_len_reg <= out_x_len;
                oy_len_reg <= out_y_len;
                group_reg  <= out_group;
                k_reg      <= kernel;
                s_reg      <= stride;
                p_reg      <= pad;
            end
            if (load_beat) begin
                valid_reg <= 1'b1;
                pad_reg   <= pad_calc;
                addr_reg  <= pad_calc ? '0 : addr_calc;
            end else if (clear_beat) begin
                valid_reg <= 1'b0;
                pad_reg   <= 1'b0;
                addr_reg  <= '0;
            end
        end
    end

    assign o_valid       = valid_reg;
    assign o_addr        = addr_reg;
    assign o_pad         = pad_reg;
    assign o_rd_en       = valid_reg & i_ready & ~pad_reg;
    assign o_feature_end = accept & pass_last;
    assign o_done        = done_reg;
    assign o_busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_iagu_conv_stream.sv
// Directed bench for iagu_conv_stream: full passes, stalls, gating, zero config, reset.
module tb_iagu_conv_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        wgt_load_end = 1'b0;
    logic [11:0] addr_start = '0;
    logic [7:0]  in_x_len = '0, in_y_len = '0, in_piece = '0;
    logic [7:0]  out_x_len = '0, out_y_len = '0, out_group = '0;
    logic [3:0]  kernel = '0;
    logic [1:0]  stride = '0, pad = '0;
    logic        i_ready = 1'b1;
    logic        o_valid, o_pad, o_rd_en, o_feature_end, o_done, o_busy;
    logic [11:0] o_addr;

    iagu_conv_stream dut (
        .clk(clk), .rst(rst), .start(start), .wgt_load_end(wgt_load_end),
        .addr_start(addr_start), .in_x_len(in_x_len), .in_y_len(in_y_len),
        .in_piece(in_piece), .out_x_len(out_x_len), .out_y_len(out_y_len),
        .out_group(out_group), .kernel(kernel), .stride(stride), .pad(pad),
        .o_valid(o_valid), .i_ready(i_ready), .o_addr(o_addr), .o_pad(o_pad),
        .o_rd_en(o_rd_en), .o_feature_end(o_feature_end), .o_done(o_done), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int fe_cnt = 0;
    int stall_err = 0;
    int rd_err = 0;
    logic [12:0] got_q[$];
    logic [12:0] ref_q[$];
    logic [12:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int b, input int ix, input int iy, input int ip, input int ox,
                           input int oy, input int og, input int k, input int s, input int p);
        addr_start = 12'(b);
        in_x_len = 8'(ix);  in_y_len = 8'(iy);  in_piece = 8'(ip);
        out_x_len = 8'(ox); out_y_len = 8'(oy); out_group = 8'(og);
        kernel = 4'(k); stride = 2'(s); pad = 2'(p);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Release one pass and collect its beats until the feature-end beat is accepted
    task automatic do_pass(input bit stall, input bit mid_wgt);
        int  guard;
        bit  fin;
        bit  stalled;
        logic [12:0] held;
        wgt_load_end = 1'b1;
        step();
        wgt_load_end = 1'b0;
        chk("first_valid", 32'(o_valid), 32'd1);
        fin = 1'b0;
        stalled = 1'b0;
        held = '0;
        guard = 0;
        while (!fin && guard < 3000) begin
            i_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            wgt_load_end = (mid_wgt && guard == 5) ? 1'b1 : 1'b0;
            #1;
            if (stalled && ({o_pad, o_addr} !== held || o_valid !== 1'b1)) stall_err++;
            if (o_rd_en !== (o_valid & i_ready & ~o_pad)) rd_err++;
            if (o_valid && i_ready) begin
                got_q.push_back({o_pad, o_addr});
                if (o_feature_end) begin
                    fe_cnt++;
                    fin = 1'b1;
                end
                stalled = 1'b0;
            end else if (o_valid) begin
                stalled = 1'b1;
                held = {o_pad, o_addr};
            end
            step();
            guard++;
        end
        wgt_load_end = 1'b0;
        i_ready = 1'b1;
        chk("pass_end_seen", 32'(fin), 32'd1);
        chk("valid_drop", 32'(o_valid), 32'd0);
    endtask

    initial begin
        int iy, ix, errs;

        // Reset state
        #12;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_addr", 32'(o_addr), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_fe", 32'(o_feature_end), 32'd0);
        chk("rst_rden", 32'(o_rd_en), 32'd0);
        rst = 1'b0;
        step();

        // Run A: 5x5, 2 pieces, 2 groups, k3 s1 p1, ready always high
        set_cfg(0, 5, 5, 2, 5, 5, 2, 3, 1, 1);
        exp_q.delete();
        for (int og = 0; og < 2; og++)
            for (int ip = 0; ip < 2; ip++)
                for (int kr = 0; kr < 3; kr++)
                    for (int kc = 0; kc < 3; kc++)
                        for (int oy = 0; oy < 5; oy++)
                            for (int ox = 0; ox < 5; ox++) begin
                                iy = oy + kr - 1;
                                ix = ox + kc - 1;
                                if (iy < 0 || iy >= 5 || ix < 0 || ix >= 5)
                                    exp_q.push_back(13'h1000);
                                else
                                    exp_q.push_back({1'b0, 12'(ip * 25 + iy * 5 + ix)});
                            end
        pulse_start();
        chk("A_wait_busy", 32'(o_busy), 32'd1);
        chk("A_wait_valid", 32'(o_valid), 32'd0);
        got_q.delete();
        fe_cnt = 0;
        for (int p = 0; p < 4; p++) do_pass(1'b0, 1'b0);
        chk("A_beats", 32'(got_q.size()), 32'd900);
        chk("A_fe_cnt", 32'(fe_cnt), 32'd4);
        errs = 0;
        for (int i = 0; i < 900; i++)
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) errs++;
        chk("A_seq_model", 32'(errs), 32'd0);
        chk("A_beat0_pad", 32'(got_q[0][12]), 32'd1);
        chk("A_beat6", 32'(got_q[6]), 32'd0);
        chk("A_pass2_beat6", 32'(got_q[231]), 32'd25);
        chk("A_fin_done_lo", 32'(o_done), 32'd0);
        step();
        chk("A_done", 32'(o_done), 32'd1);
        chk("A_idle", 32'(o_busy), 32'd0);
        step();
        chk("A_done_pulse", 32'(o_done), 32'd0);
        ref_q = got_q;

        // Run B: same layer with random ready stalls
        pulse_start();
        got_q.delete();
        stall_err = 0;
        for (int p = 0; p < 4; p++) do_pass(1'b1, 1'b0);
        errs = 0;
        for (int i = 0; i < 900; i++)
            if (i >= got_q.size() || got_q[i] !== ref_q[i]) errs++;
        chk("B_beats", 32'(got_q.size()), 32'd900);
        chk("B_seq_same", 32'(errs), 32'd0);
        chk("B_stall_stable", 32'(stall_err), 32'd0);
        step();
        chk("B_done", 32'(o_done), 32'd1);

        // Run C: in 5x5, out 2x2, k3 s2 p0, base 100
        set_cfg(100, 5, 5, 1, 2, 2, 1, 3, 2, 0);
        pulse_start();
        got_q.delete();
        do_pass(1'b0, 1'b0);
        chk("C_beats", 32'(got_q.size()), 32'd36);
        chk("C_b0", 32'(got_q[0]), 32'd100);
        chk("C_b1", 32'(got_q[1]), 32'd102);
        chk("C_b2", 32'(got_q[2]), 32'd110);
        chk("C_b3", 32'(got_q[3]), 32'd112);
        step();
        chk("C_done", 32'(o_done), 32'd1);

        // Run D: weight gating, stray start, mid-run wgt pulse not queued
        set_cfg(100, 5, 5, 2, 2, 2, 1, 3, 2, 0);
        pulse_start();
        for (int i = 0; i < 20; i++) step();
        chk("D_wait_valid", 32'(o_valid), 32'd0);
        chk("D_wait_busy", 32'(o_busy), 32'd1);
        out_x_len = 8'd0;
        pulse_start();
        step();
        chk("D_stray_start_done", 32'(o_done), 32'd0);
        chk("D_stray_start_busy", 32'(o_busy), 32'd1);
        out_x_len = 8'd2;
        got_q.delete();
        do_pass(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step();
        chk("D_no_queue_valid", 32'(o_valid), 32'd0);
        chk("D_no_queue_busy", 32'(o_busy), 32'd1);
        do_pass(1'b0, 1'b0);
        chk("D_beats", 32'(got_q.size()), 32'd72);
        chk("D_pass2_b0", 32'(got_q[36]), 32'd125);
        step();
        chk("D_done", 32'(o_done), 32'd1);
        chk("D_rd_en", 32'(rd_err), 32'd0);

        // Run E: zero output width finishes without beats
        set_cfg(0, 5, 5, 1, 0, 5, 1, 3, 1, 0);
        pulse_start();
        chk("E_done_early", 32'(o_done), 32'd0);
        step();
        chk("E_done", 32'(o_done), 32'd1);
        chk("E_valid", 32'(o_valid), 32'd0);

        // Run F: reset mid-run, then restart
        set_cfg(0, 5, 5, 2, 5, 5, 2, 3, 1, 1);
        pulse_start();
        wgt_load_end = 1'b1;
        step();
        wgt_load_end = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("F_running", 32'(o_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("F_rst_valid", 32'(o_valid), 32'd0);
        chk("F_rst_busy", 32'(o_busy), 32'd0);
        chk("F_rst_addr", 32'(o_addr), 32'd0);
        chk("F_rst_fe", 32'(o_feature_end), 32'd0);
        step();
        rst = 1'b0;
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (o_done !== 1'b0) errs++;
        end
        chk("F_no_done", 32'(errs), 32'd0);
        set_cfg(100, 5, 5, 1, 2, 2, 1, 3, 2, 0);
        pulse_start();
        got_q.delete();
        do_pass(1'b0, 1'b0);
        chk("F_restart_b0", 32'(got_q[0]), 32'd100);
        step();
        chk("F_restart_done", 32'(o_done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
